// File: rtl/mem_io_router_pkg.sv
// Shared definitions for the memory/IO router: FSM encoding, default region
// table (interrupt controller at 0x7000, everything else to the cache) and sizing helpers.
package mem_io_router_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_BUSY = 2'd1;
    localparam state_t ST_RESP = 2'd2;

    localparam logic [15:0] INTR_BASE = 16'h7000;
    localparam logic [15:0] INTR_MASK = 16'h7000;

    // Slice 0 is the interrupt region; slice 1 is a catch-all (mask 0).
    localparam logic [31:0] DEF_TGT_BASE = {16'h0000, INTR_BASE};
    localparam logic [31:0] DEF_TGT_MASK = {16'h0000, INTR_MASK};

    function automatic int sel_width(input int n_tgt);
        return (n_tgt > 1) ? $clog2(n_tgt) : 1;
    endfunction

    function automatic int cnt_width(input int timeout);
        return (timeout > 1) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/mem_io_router_if.sv
// Bus bundle between the pipeline master port and the routed targets.
interface mem_io_router_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 128,
    parameter int N_TGT  = 2
);
    // Master: M_EN is held until the one-cycle M_R pulse, which carries
    // M_RDATA/M_ERR. Targets: T_EN is held while waiting; T_R of the enabled target completes.
    logic                    M_EN;
    logic                    M_WR;
    logic [ADDR_W-1:0]       M_A;
    logic [DATA_W-1:0]       M_WDATA;
    logic [DATA_W-1:0]       M_RDATA;
    logic                    M_R;
    logic                    M_ERR;
    logic                    BUSY;
    logic [N_TGT-1:0]        T_EN;
    logic                    T_WR;
    logic [ADDR_W-1:0]       T_A;
    logic [DATA_W-1:0]       T_WDATA;
    logic [N_TGT*DATA_W-1:0] T_RDATA;
    logic [N_TGT-1:0]        T_R;

    modport slave (
        input  M_EN, M_WR, M_A, M_WDATA, T_RDATA, T_R,
        output M_RDATA, M_R, M_ERR, BUSY, T_EN, T_WR, T_A, T_WDATA
    );

    modport master (
        output M_EN, M_WR, M_A, M_WDATA, T_RDATA, T_R,
        input  M_RDATA, M_R, M_ERR, BUSY, T_EN, T_WR, T_A, T_WDATA
    );

endinterface

// File: rtl/mem_io_decode.sv
// Combinational base/mask region decoder; the lowest matching target index wins.
module mem_io_decode
    import mem_io_router_pkg::*;
#(
    parameter int                      ADDR_W   = 16,
    parameter int                      N_TGT    = 2,
    parameter int                      SEL_W    = 1,
    parameter logic [N_TGT*ADDR_W-1:0] TGT_BASE = DEF_TGT_BASE,
    parameter logic [N_TGT*ADDR_W-1:0] TGT_MASK = DEF_TGT_MASK
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic [SEL_W-1:0]  sel_o,
    output logic              hit_o
);

    // Scanning from the top down lets the lowest matching index overwrite last.
    always_comb begin
        sel_o = '0;
        hit_o = 1'b0;
        for (int i = N_TGT - 1; i >= 0; i--) begin
            if ((addr_i & TGT_MASK[i*ADDR_W +: ADDR_W]) == TGT_BASE[i*ADDR_W +: ADDR_W]) begin
                sel_o = SEL_W'(i);
                hit_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_io_router.sv
// Routes the single DC_IO master port to N_TGT memory-mapped targets, one request
// in flight, with an error response for unmapped addresses or silent targets.
module mem_io_router
    import mem_io_router_pkg::*;
#(
    parameter int                      ADDR_W   = 16,
    parameter int                      DATA_W   = 128,
    parameter int                      N_TGT    = 2,
    parameter logic [N_TGT*ADDR_W-1:0] TGT_BASE = DEF_TGT_BASE,
    parameter logic [N_TGT*ADDR_W-1:0] TGT_MASK = DEF_TGT_MASK,
    parameter int                      TIMEOUT  = 255
) (
    input  logic                   CLK,
    input  logic                   RST,
    mem_io_router_if.slave         bus,
    output logic [1:0]             dbg_state_o
);

    localparam int SEL_W = sel_width(N_TGT);
    localparam int CNT_W = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SEL_W-1:0]  dec_sel;
    logic              dec_hit;
    logic [N_TGT-1:0]  en_vec;

    mem_io_decode #(
        .ADDR_W   (ADDR_W),
        .N_TGT    (N_TGT),
        .SEL_W    (SEL_W),
        .TGT_BASE (TGT_BASE),
        .TGT_MASK (TGT_MASK)
    ) u_decode (
        .addr_i (bus.M_A),
        .sel_o  (dec_sel),
        .hit_o  (dec_hit)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        wr_d    = wr_q;
        a_d     = a_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.M_EN) begin
                    rdata_d = '0;
                    if (dec_hit) begin
                        sel_d   = dec_sel;
                        wr_d    = bus.M_WR;
                        a_d     = bus.M_A;
                        wdata_d = bus.M_WDATA;
                        cnt_d   = '0;
                        err_d   = 1'b0;
                        state_d = ST_BUSY;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_BUSY: begin
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
                // Ready is tested first so it beats a timeout landing on the same cycle.
                if (bus.T_R[sel_q]) begin
                    rdata_d = wr_q ? '0 : bus.T_RDATA[int'(sel_q)*DATA_W +: DATA_W];
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if ((TIMEOUT != 0) && (cnt_q == TMO_LAST)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            wr_q    <= 1'b0;
            a_q     <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            wr_q    <= wr_d;
            a_q     <= a_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        en_vec = '0;
        if (state_q == ST_BUSY) en_vec[sel_q] = 1'b1;
    end

    assign bus.T_EN    = en_vec;
    assign bus.T_WR    = wr_q;
    assign bus.T_A     = a_q;
    assign bus.T_WDATA = wdata_q;
    assign bus.M_RDATA = rdata_q;
    assign bus.M_ERR   = err_q;
    assign bus.M_R     = (state_q == ST_RESP);
    assign bus.BUSY    = (state_q == ST_BUSY);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_io_router.sv
// Bench for mem_io_router: default map (TIMEOUT 255) and a no-catch-all map (TIMEOUT 4),
// exercised one after the other against a region-table reference model.
module tb_mem_io_router;
    import mem_io_router_pkg::*;

    localparam int AW = 16;
    localparam int DW = 128;
    localparam int NT = 2;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        int            lat;
        int            start;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    int            cur = 0;
    int            cyc = 0;
    int            n_chk = 0;
    int            n_fail = 0;
    exp_t          exp_q[$];

    logic             m_en = 1'b0;
    logic             m_wr = 1'b0;
    logic [AW-1:0]    m_a = '0;
    logic [DW-1:0]    m_wdata = '0;
    logic [NT*DW-1:0] t_rdata = '0;
    logic [NT-1:0]    t_r = '0;

    logic [NT-1:0] cur_en = '0;
    logic          cur_wr = 1'b0;
    logic [AW-1:0] cur_a = '0;
    logic [DW-1:0] cur_wd = '0;
    int            cur_k = 1;
    int            busy_n = 0;

    // Region tables of the two configurations, index [config][target].
    logic [AW-1:0] base_t [2][NT] = '{'{16'h7000, 16'h0000}, '{16'h1000, 16'h2000}};
    logic [AW-1:0] mask_t [2][NT] = '{'{16'h7000, 16'h0000}, '{16'hF000, 16'hF000}};
    int            tmo_t  [2]     = '{255, 4};

    logic [1:0] dbg0, dbg1;

    mem_io_router_if #(.ADDR_W(AW), .DATA_W(DW), .N_TGT(NT)) bus0 ();
    mem_io_router_if #(.ADDR_W(AW), .DATA_W(DW), .N_TGT(NT)) bus1 ();

    assign bus0.M_EN    = m_en && (cur == 0);
    assign bus1.M_EN    = m_en && (cur == 1);
    assign bus0.M_WR    = m_wr;
    assign bus1.M_WR    = m_wr;
    assign bus0.M_A     = m_a;
    assign bus1.M_A     = m_a;
    assign bus0.M_WDATA = m_wdata;
    assign bus1.M_WDATA = m_wdata;
    assign bus0.T_RDATA = t_rdata;
    assign bus1.T_RDATA = t_rdata;
    assign bus0.T_R     = t_r;
    assign bus1.T_R     = t_r;

    logic [DW-1:0] o_rdata, o_twd;
    logic          o_r, o_err, o_busy, o_twr;
    logic [NT-1:0] o_ten;
    logic [AW-1:0] o_ta;
    logic [1:0]    o_state;

    assign o_rdata = (cur == 1) ? bus1.M_RDATA : bus0.M_RDATA;
    assign o_r     = (cur == 1) ? bus1.M_R     : bus0.M_R;
    assign o_err   = (cur == 1) ? bus1.M_ERR   : bus0.M_ERR;
    assign o_busy  = (cur == 1) ? bus1.BUSY    : bus0.BUSY;
    assign o_ten   = (cur == 1) ? bus1.T_EN    : bus0.T_EN;
    assign o_twr   = (cur == 1) ? bus1.T_WR    : bus0.T_WR;
    assign o_ta    = (cur == 1) ? bus1.T_A     : bus0.T_A;
    assign o_twd   = (cur == 1) ? bus1.T_WDATA : bus0.T_WDATA;
    assign o_state = (cur == 1) ? dbg1         : dbg0;

    mem_io_router #(
        .ADDR_W(AW), .DATA_W(DW), .N_TGT(NT),
        .TGT_BASE({16'h0000, 16'h7000}), .TGT_MASK({16'h0000, 16'h7000}),
        .TIMEOUT(255)
    ) dut0 (.CLK(clk), .RST(rst), .bus(bus0), .dbg_state_o(dbg0));

    mem_io_router #(
        .ADDR_W(AW), .DATA_W(DW), .N_TGT(NT),
        .TGT_BASE({16'h2000, 16'h1000}), .TGT_MASK({16'hF000, 16'hF000}),
        .TIMEOUT(4)
    ) dut1 (.CLK(clk), .RST(rst), .bus(bus1), .dbg_state_o(dbg1));

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_m_r"},     o_r,     '0);
        chk({tag, "_m_err"},   o_err,   '0);
        chk({tag, "_m_rdata"}, o_rdata, '0);
        chk({tag, "_busy"},    o_busy,  '0);
        chk({tag, "_t_en"},    o_ten,   '0);
        chk({tag, "_t_wr"},    o_twr,   '0);
        chk({tag, "_t_a"},     o_ta,    '0);
        chk({tag, "_t_wdata"}, o_twd,   '0);
        chk({tag, "_state"},   o_state, ST_IDLE);
    endtask

    // ---------------- reference model ----------------
    function automatic void model_decode(input int d, input logic [AW-1:0] a,
                                         output bit hit, output int sel);
        hit = 1'b0;
        sel = 0;
        for (int i = 0; i < NT; i++) begin
            if (!hit && ((a & mask_t[d][i]) == base_t[d][i])) begin
                hit = 1'b1;
                sel = i;
            end
        end
    endfunction

    // ---------------- target responder ----------------
    // The enabled target answers from its k-th enabled cycle on; others toggle randomly.
    always @(posedge clk) begin
        #1;
        if (o_ten != '0) busy_n++;
        else busy_n = 0;
        for (int i = 0; i < NT; i++)
            t_r[i] = o_ten[i] ? (busy_n >= cur_k) : 1'($urandom_range(0, 1));
    end

    // ---------------- driver ----------------
    task automatic wait_resp();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_r && n < 600);
        m_en = 1'b0;
        if (!o_r) begin
            chk("resp_wait_bound", o_r, 1);
            exp_q.delete();
            @(posedge clk); #1; rst = 1'b1;
            @(posedge clk); #1; rst = 1'b0;
        end
    endtask

    task automatic do_req(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input int k, input bit rand_rd);
        exp_t e;
        bit   hit;
        int   sel;
        int   tmo;
        @(posedge clk); #1;
        model_decode(cur, a, hit, sel);
        tmo = tmo_t[cur];
        if (rand_rd) for (int j = 0; j < NT * DW / 32; j++) t_rdata[j*32 +: 32] = $urandom();
        if (!hit) begin
            e.err = 1'b1; e.rdata = '0; e.lat = 1;
        end else if (tmo != 0 && k > tmo) begin
            e.err = 1'b1; e.rdata = '0; e.lat = tmo + 1;
        end else begin
            e.err = 1'b0; e.rdata = wr ? '0 : t_rdata[sel*DW +: DW]; e.lat = k + 1;
        end
        e.start = cyc;
        exp_q.push_back(e);
        cur_en = hit ? NT'(1 << sel) : '0;
        cur_wr = wr; cur_a = a; cur_wd = wd; cur_k = k;
        m_en = 1'b1; m_wr = wr; m_a = a; m_wdata = wd;
        @(posedge clk); #1;
        m_wr = 1'($urandom_range(0, 1));
        m_a = AW'($urandom());
        for (int j = 0; j < DW / 32; j++) m_wdata[j*32 +: 32] = $urandom();
        wait_resp();
    endtask

    task automatic rand_req(input int d);
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        int            pick;
        pick = $urandom_range(0, 2);
        a = AW'($urandom());
        if (d == 0) begin
            if (pick == 0) a[15:12] = 4'h7;
            if (pick == 1) a[15:12] = 4'hF;
        end else begin
            if (pick == 0) a[15:12] = 4'h1;
            if (pick == 1) a[15:12] = 4'h2;
        end
        for (int j = 0; j < DW / 32; j++) wd[j*32 +: 32] = $urandom();
        do_req(1'($urandom_range(0, 1)), a, wd, $urandom_range(1, 6), 1'b1);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst) begin
            chk("busy_vs_t_en", o_busy, (o_ten != '0));
            if (o_ten != '0) begin
                chk("t_en",    o_ten, cur_en);
                chk("t_a",     o_ta,  cur_a);
                chk("t_wr",    o_twr, cur_wr);
                chk("t_wdata", o_twd, cur_wd);
            end
            if (o_r) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_m_r", o_r, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("m_rdata", o_rdata, e.rdata);
                    chk("m_err",   o_err,   e.err);
                    chk("latency", cyc - e.start, e.lat);
                    chk("resp_state", o_state, ST_RESP);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [DW-1:0] wd;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset0");
        @(posedge clk); #1; rst = 1'b0;

        // Default map: interrupt read, catch-all write, long timeout.
        t_rdata = '0;
        t_rdata[DW-1:0] = 128'hA5;
        do_req(1'b0, 16'h7010, '0, 2, 1'b0);
        do_req(1'b1, 16'h1230, 128'h55, 1, 1'b1);
        do_req(1'b0, 16'h7000, '0, 300, 1'b1);

        // Reset while BUSY aborts without a response.
        @(posedge clk); #1;
        cur_en = 2'b01; cur_a = 16'h7ABC; cur_wr = 1'b0; cur_wd = 128'h1234; cur_k = 100000;
        m_en = 1'b1; m_a = 16'h7ABC; m_wr = 1'b0; m_wdata = 128'h1234;
        repeat (3) @(posedge clk);
        #1; rst = 1'b1; m_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_idle("mid_reset");
        @(posedge clk); #1; rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("no_m_r_after_reset", o_r, 0);
        end
        do_req(1'b0, 16'h7004, '0, 1, 1'b1);

        repeat (30) rand_req(0);

        // Second map: no catch-all, TIMEOUT 4.
        @(posedge clk); #1; cur = 1; rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle("reset1");
        @(posedge clk); #1; rst = 1'b0;

        do_req(1'b0, 16'h5000, '0, 1, 1'b1);
        do_req(1'b1, 16'h9ABC, 128'h77, 1, 1'b1);
        do_req(1'b0, 16'h1100, '0, 100, 1'b1);
        do_req(1'b0, 16'h2200, '0, 4, 1'b1);
        wd = 128'hCAFE;
        do_req(1'b1, 16'h1000, wd, 5, 1'b1);
        do_req(1'b0, 16'h2FFF, '0, 3, 1'b1);

        repeat (30) rand_req(1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("exp_q_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_io_router.md
Name: mem_io_router

Overview:
- Parametrised successor to the fixed DCACHE/interrupt-controller address split at the top level.
- Routes one master memory port (the pipeline's DC_IO port) to N_TGT memory-mapped targets using a base/mask region table.
- Tracks one outstanding request at a time, returns the selected target's read data, and generates a timeout error response for unresponsive or unmapped addresses.

Parameters:
ADDR_W, 16, address width
DATA_W, 128, data width (one cache line)
N_TGT, 2, number of targets
TGT_BASE, {16'h0000,16'h7000}, packed N_TGT*ADDR_W; slice i is target i base
TGT_MASK, {16'h0000,16'h7000}, packed N_TGT*ADDR_W; target i matches when (M_A & mask_i) == base_i
TIMEOUT, 255, max cycles in BUSY before error; 0 disables the timeout

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
M_EN  in  1  master request, level held until M_R
M_WR  in  1  1 = write, 0 = read
M_A  in  ADDR_W  request address
M_WDATA  in  DATA_W  write data
M_RDATA  out  DATA_W  read data, valid while M_R = 1
M_R  out  1  one-cycle completion pulse
M_ERR  out  1  error flag, valid with M_R
BUSY  out  1  request outstanding
T_EN  out  N_TGT  one-hot target enable
T_WR  out  1  latched M_WR, broadcast to all targets
T_A  out  ADDR_W  latched address, broadcast
T_WDATA  out  DATA_W  latched write data, broadcast
T_RDATA  in  N_TGT*DATA_W  slice i is target i read data
T_R  in  N_TGT  target ready

Behaviour:
- Reset values (RST sampled high at a CLK edge): state = IDLE; all outputs 0; timeout counter 0.
- Reset mid-operation: abort immediately, drop T_EN, emit no M_R.
- Decode is combinational on M_A. The lowest matching index wins. No match means unmapped.
- FSM states: IDLE, BUSY, RESP.
- IDLE with M_EN = 1 and a mapped address:
  - Latch M_WR, M_A, M_WDATA and sel into registers; clear the counter.
  - Next cycle: BUSY with T_EN[sel] = 1.
- IDLE with M_EN = 1 and an unmapped address:
  - Next state RESP with M_ERR = 1 and M_RDATA = 0, so latency is 1 cycle.
  - T_EN is never asserted for this request.
- BUSY:
  - T_EN[sel] held high; BUSY = 1; counter increments each cycle.
  - If T_R[sel] = 1: capture the T_RDATA sel slice into M_RDATA (reads only; writes return 0); go to RESP with M_ERR = 0.
  - Else if TIMEOUT != 0 and counter == TIMEOUT-1: go to RESP with M_ERR = 1 and M_RDATA = 0.
  - If T_R[sel] and the timeout fall in the same cycle, ready wins (no error).
  - T_R from unselected targets is ignored.
- RESP:
  - M_R = 1 for exactly one cycle, T_EN = 0, then IDLE.
  - M_EN is ignored during RESP.
  - The master must drop M_EN in the cycle after M_R. If M_EN is still high in IDLE, it is taken as a new request.
- Minimum latency from M_EN to M_R:
  - Mapped target with T_R already high on entering BUSY: 2 cycles (IDLE→BUSY→RESP, M_R visible in the 3rd cycle).
  - Unmapped address: 1 cycle.
- Latched T_A/T_WR/T_WDATA stay stable across BUSY, regardless of changes on M_A, M_WR or M_WDATA.
- The counter is wide enough to hold TIMEOUT. It saturates and does not wrap.

Decomposition:
- Shared package: FSM state encoding (IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2) and the default region constants (INTR region 0x7000/0x7000).
- One sub-module is natural: mem_io_decode. It is a purely combinational base/mask priority encoder with outputs sel index and hit.

Test Plan:
- Defaults; read M_A = 0x7010, T_R[0] high on the 2nd BUSY cycle with T_RDATA slice0 = 128'hA5 → T_EN = 2'b01 for 2 cycles, M_R pulse with M_RDATA = 128'hA5, M_ERR = 0.
- Defaults; write M_A = 0x1230, M_WDATA = 128'h55, T_R[1] immediate → T_EN = 2'b10, T_WR = 1, T_WDATA = 128'h55, M_R after 2 cycles, M_RDATA = 0.
- N_TGT = 2, no catch-all (both masks 0xF000, bases 0x1000 and 0x2000); M_A = 0x5000 → no T_EN, M_R = 1 and M_ERR = 1 the cycle after accept.
- TIMEOUT = 4, T_R held low → T_EN high 4 cycles, then M_R with M_ERR = 1. Repeat with T_R[sel] rising on the 4th cycle → M_ERR = 0.
- RST asserted during BUSY → next cycle T_EN = 0, BUSY = 0, no M_R. A new request after reset completes normally.
- Stray T_R[1] pulses while sel = 0 → ignored; M_R occurs only on T_R[0].
